// File: rtl/cam_capture_pkg.sv
// Shared types and defaults for the camera capture engine: FSM states,
// default frame geometry and the decimation-factor check.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    FRAME  = 2'd2,
    LINE   = 2'd3
  } cap_state_e;

  localparam int unsigned DEF_DATA_W        = 8;
  localparam int unsigned DEF_BYTES_PER_PIX = 2;
  localparam int unsigned DEF_H_ACTIVE      = 640;
  localparam int unsigned DEF_V_ACTIVE      = 480;
  localparam int unsigned DEF_DECIM         = 1;
  localparam int unsigned DEF_ADDR_W        = 20;
  localparam int unsigned DEF_FCNT_W        = 16;

  function automatic bit decim_legal(input int unsigned decim);
    return (decim == 1) || (decim == 2);
  endfunction

endpackage

// File: rtl/cam_capture_gen2_if.sv
// Frame-buffer write port: one pixel per cycle while we is high.
interface cam_capture_gen2_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned PIX_W  = 16
);

  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  dout;
  logic              we;

  modport master (output addr, output dout, output we);
  modport slave  (input  addr, input  dout, input  we);

endinterface

// File: rtl/cam_byte_packer.sv
// Collects BYTES_PER_PIX consecutive bus beats into one pixel, first beat in
// the MSBs. pix_valid_o is combinational on the beat that completes a pixel.
module cam_byte_packer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BYTES_PER_PIX = 2
) (
  input  logic                              pclk,
  input  logic                              rst,
  input  logic                              clr_i,
  input  logic                              en_i,
  input  logic [DATA_W-1:0]                 din_i,
  output logic                              pix_valid_o,
  output logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data_o
);

  localparam int unsigned PH_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(BYTES_PER_PIX - 1);

  logic [PH_W-1:0] phase_q, phase_d;

  assign pix_valid_o = en_i && (phase_q == LAST_PH);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = pix_valid_o ? '0 : phase_q + PH_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  generate
    if (BYTES_PER_PIX == 1) begin : g_single
      assign pix_data_o = din_i;
    end else begin : g_multi
      localparam int unsigned SH_W = DATA_W * (BYTES_PER_PIX - 1);
      logic [SH_W-1:0] shift_q;

      // The completing beat goes straight to the output, so only the earlier
      // beats need storage.
      assign pix_data_o = {shift_q, din_i};

      always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
          shift_q <= '0;
        end else if (en_i) begin
          shift_q <= pix_data_o[SH_W-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cam_capture_gen2.sv
// DVP camera capture engine: frame/line tracking, pixel assembly, optional 2:1
// decimation, geometry checks and linear frame-buffer writes, all on pclk.
module cam_capture_gen2
  import cam_capture_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned BYTES_PER_PIX = DEF_BYTES_PER_PIX,
  parameter int unsigned H_ACTIVE      = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE      = DEF_V_ACTIVE,
  parameter int unsigned DECIM         = DEF_DECIM,
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned FCNT_W        = DEF_FCNT_W
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 vsync_i,
  input  logic                 href_i,
  input  logic [DATA_W-1:0]    din_i,
  input  logic                 arm_i,
  cam_capture_gen2_if.master   fb,
  output logic                 capture_end_o,
  output logic                 frame_active_o,
  output logic [FCNT_W-1:0]    frame_cnt_o,
  output logic                 err_hlen_o,
  output logic                 err_vlen_o
);

  localparam int unsigned PIX_W = DATA_W * BYTES_PER_PIX;
  // An illegal decimation factor falls back to full resolution.
  localparam int unsigned DEC   = decim_legal(DECIM) ? DECIM : 1;
  localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0] H_LIM = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] V_LIM = ROW_W'(V_ACTIVE);

  cap_state_e state_q, state_d;
  logic frame_start, frame_end, line_end;

  logic             sample_en;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;

  logic              armed_q, armed_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  dout_q, dout_d;
  logic              err_hlen_q, err_hlen_d;
  logic              err_vlen_q, err_vlen_d;
  logic              frame_active_q, frame_active_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              end_pend_q, end_pend_d;
  logic              capture_end_q, capture_end_d;

  logic col_lim, row_lim, decim_ok, keep;

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_end    = 1'b0;
    case (state_q)
      SYNC: begin
        if (vsync_i) state_d = VBLANK;
      end
      VBLANK: begin
        if (!vsync_i) begin
          state_d     = FRAME;
          frame_start = 1'b1;
        end
      end
      FRAME: begin
        if (vsync_i) begin
          state_d   = VBLANK;
          frame_end = 1'b1;
        end else if (href_i) begin
          state_d = LINE;
        end
      end
      LINE: begin
        if (vsync_i) begin
          state_d   = VBLANK;
          frame_end = 1'b1;
          line_end  = 1'b1;
        end else if (!href_i) begin
          state_d  = FRAME;
          line_end = 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // The beat that raises href is sampled on the FRAME->LINE edge itself.
  assign sample_en = href_i && ((state_q == FRAME) || (state_q == LINE));

  cam_byte_packer #(
    .DATA_W        (DATA_W),
    .BYTES_PER_PIX (BYTES_PER_PIX)
  ) u_packer (
    .pclk        (pclk),
    .rst         (rst),
    .clr_i       (frame_start || line_end),
    .en_i        (sample_en),
    .din_i       (din_i),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data)
  );

  assign col_lim  = (col_q >= H_LIM);
  assign row_lim  = (row_q >= V_LIM);
  assign decim_ok = (DEC == 1) || (!col_q[0] && !row_q[0]);
  assign keep     = pix_valid && armed_q && !col_lim && !row_lim && decim_ok;

  always_comb begin
    armed_d        = armed_q;
    col_d          = col_q;
    row_d          = row_q;
    waddr_d        = waddr_q;
    we_d           = 1'b0;
    addr_d         = addr_q;
    dout_d         = dout_q;
    err_hlen_d     = err_hlen_q;
    err_vlen_d     = err_vlen_q;
    frame_active_d = frame_active_q;
    frame_cnt_d    = frame_cnt_q;
    end_pend_d     = 1'b0;
    capture_end_d  = 1'b0;

    // col saturates at H_ACTIVE so an overlong line cannot wrap back in range.
    if (pix_valid) begin
      if (col_lim) err_hlen_d = 1'b1;
      else         col_d      = col_q + COL_W'(1);
    end
    if (sample_en && row_lim) err_vlen_d = 1'b1;

    if (keep) begin
      we_d    = 1'b1;
      addr_d  = waddr_q;
      dout_d  = pix_data;
      waddr_d = waddr_q + ADDR_W'(1);
    end

    if (line_end) begin
      col_d = '0;
      if ((col_q != '0) && !row_lim) row_d = row_q + ROW_W'(1);
    end

    // End-of-frame status trails by one cycle so a pixel completed on the
    // vsync edge is written before capture_end.
    if (frame_end && armed_q) end_pend_d = 1'b1;
    if (end_pend_q) begin
      capture_end_d  = 1'b1;
      frame_cnt_d    = frame_cnt_q + FCNT_W'(1);
      frame_active_d = 1'b0;
    end

    if (frame_start) begin
      armed_d        = arm_i;
      col_d          = '0;
      row_d          = '0;
      waddr_d        = '0;
      err_hlen_d     = 1'b0;
      err_vlen_d     = 1'b0;
      frame_active_d = arm_i;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      armed_q        <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      waddr_q        <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      dout_q         <= '0;
      err_hlen_q     <= 1'b0;
      err_vlen_q     <= 1'b0;
      frame_active_q <= 1'b0;
      frame_cnt_q    <= '0;
      end_pend_q     <= 1'b0;
      capture_end_q  <= 1'b0;
    end else begin
      armed_q        <= armed_d;
      col_q          <= col_d;
      row_q          <= row_d;
      waddr_q        <= waddr_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      dout_q         <= dout_d;
      err_hlen_q     <= err_hlen_d;
      err_vlen_q     <= err_vlen_d;
      frame_active_q <= frame_active_d;
      frame_cnt_q    <= frame_cnt_d;
      end_pend_q     <= end_pend_d;
      capture_end_q  <= capture_end_d;
    end
  end

  assign fb.we          = we_q;
  assign fb.addr        = addr_q;
  assign fb.dout        = dout_q;
  assign capture_end_o  = capture_end_q;
  assign frame_active_o = frame_active_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign err_hlen_o     = err_hlen_q;
  assign err_vlen_o     = err_vlen_q;

endmodule

// File: tb/tb_cam_capture_gen2.sv
// Directed bench: instance A (2-byte pixels, 4x2) and instance B (1-byte
// pixels, 4x4, 2:1 decimation); writes are logged at negedge and checked.
module tb_cam_capture_gen2;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  always #5 pclk = ~pclk;

  // Instance A
  logic        a_vsync = 1'b0, a_href = 1'b0, a_arm = 1'b0;
  logic [7:0]  a_din = 8'h00;
  logic        a_ce, a_fa, a_eh, a_ev;
  logic [15:0] a_fcnt;

  cam_capture_gen2_if #(.ADDR_W(8), .PIX_W(16)) a_fb ();

  cam_capture_gen2 #(
    .DATA_W(8), .BYTES_PER_PIX(2), .H_ACTIVE(4), .V_ACTIVE(2),
    .DECIM(1), .ADDR_W(8), .FCNT_W(16)
  ) u_a (
    .pclk(pclk), .rst(rst), .vsync_i(a_vsync), .href_i(a_href), .din_i(a_din),
    .arm_i(a_arm), .fb(a_fb), .capture_end_o(a_ce), .frame_active_o(a_fa),
    .frame_cnt_o(a_fcnt), .err_hlen_o(a_eh), .err_vlen_o(a_ev)
  );

  // Instance B
  logic        b_vsync = 1'b0, b_href = 1'b0, b_arm = 1'b0;
  logic [7:0]  b_din = 8'h00;
  logic        b_ce, b_fa, b_eh, b_ev;
  logic [15:0] b_fcnt;

  cam_capture_gen2_if #(.ADDR_W(8), .PIX_W(8)) b_fb ();

  cam_capture_gen2 #(
    .DATA_W(8), .BYTES_PER_PIX(1), .H_ACTIVE(4), .V_ACTIVE(4),
    .DECIM(2), .ADDR_W(8), .FCNT_W(16)
  ) u_b (
    .pclk(pclk), .rst(rst), .vsync_i(b_vsync), .href_i(b_href), .din_i(b_din),
    .arm_i(b_arm), .fb(b_fb), .capture_end_o(b_ce), .frame_active_o(b_fa),
    .frame_cnt_o(b_fcnt), .err_hlen_o(b_eh), .err_vlen_o(b_ev)
  );

  logic [7:0]  a_q_addr[$];
  logic [15:0] a_q_dout[$];
  int          a_ce_n = 0;
  logic [7:0]  b_q_addr[$];
  logic [7:0]  b_q_dout[$];
  int          b_ce_n = 0;

  always @(negedge pclk) begin
    if (a_fb.we === 1'b1) begin
      a_q_addr.push_back(a_fb.addr);
      a_q_dout.push_back(a_fb.dout);
    end
    if (a_ce === 1'b1) a_ce_n++;
    if (b_fb.we === 1'b1) begin
      b_q_addr.push_back(b_fb.addr);
      b_q_dout.push_back(b_fb.dout);
    end
    if (b_ce === 1'b1) b_ce_n++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] a_addr_at(input int i);
    if (i < a_q_addr.size()) return 32'(a_q_addr[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] a_dout_at(input int i);
    if (i < a_q_dout.size()) return 32'(a_q_dout[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] b_addr_at(input int i);
    if (i < b_q_addr.size()) return 32'(b_q_addr[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] b_dout_at(input int i);
    if (i < b_q_dout.size()) return 32'(b_q_dout[i]);
    return 'x;
  endfunction

  task automatic a_clear();
    a_q_addr.delete();
    a_q_dout.delete();
    a_ce_n = 0;
  endtask

  task automatic a_step(input logic vs, input logic hr, input logic [7:0] d);
    a_vsync = vs;
    a_href  = hr;
    a_din   = d;
    @(posedge pclk);
    #1;
  endtask

  task automatic a_vblank(input int n);
    for (int i = 0; i < n; i++) a_step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic a_line(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) a_step(1'b0, 1'b1, first + 8'(i));
    a_step(1'b0, 1'b0, 8'h00);
    a_step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic b_step(input logic vs, input logic hr, input logic [7:0] d);
    b_vsync = vs;
    b_href  = hr;
    b_din   = d;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge pclk);
    #1;
    check("rst_we",     32'(a_fb.we),   32'h0);
    check("rst_addr",   32'(a_fb.addr), 32'h0);
    check("rst_dout",   32'(a_fb.dout), 32'h0);
    check("rst_status", {27'h0, a_ce, a_fa, a_eh, a_ev, 1'b0}, 32'h0);
    check("rst_fcnt",   32'(a_fcnt),    32'h0);
    rst = 1'b0;

    // Armed 4x2 frame, bytes 0x01..0x10
    a_arm = 1'b1;
    a_vblank(2);
    a_step(1'b0, 1'b0, 8'h00);
    check("t1_active", 32'(a_fa), 32'h1);
    a_line(8'h01, 8);
    a_line(8'h09, 8);
    a_vblank(3);
    check("t1_nwr", 32'(a_q_addr.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_addr%0d", k), a_addr_at(k), 32'(k));
      check($sformatf("t1_dout%0d", k), a_dout_at(k),
            {16'h0, 8'(2 * k + 1), 8'(2 * k + 2)});
    end
    check("t1_dout_last", a_dout_at(7), 32'h0F10);
    check("t1_ce",     32'(a_ce_n), 32'd1);
    check("t1_fcnt",   32'(a_fcnt), 32'd1);
    check("t1_inact",  32'(a_fa),   32'h0);
    check("t1_errs",   {30'h0, a_eh, a_ev}, 32'h0);

    // Unarmed frame with arm raised mid-frame, then an armed frame
    a_clear();
    a_arm = 1'b0;
    a_step(1'b0, 1'b0, 8'h00);
    check("t2_unarmed_active", 32'(a_fa), 32'h0);
    a_line(8'h21, 8);
    a_arm = 1'b1;
    a_line(8'h31, 8);
    a_vblank(3);
    check("t2_unarmed_nwr",  32'(a_q_addr.size()), 32'd0);
    check("t2_unarmed_ce",   32'(a_ce_n), 32'd0);
    check("t2_unarmed_fcnt", 32'(a_fcnt), 32'd1);
    a_clear();
    a_step(1'b0, 1'b0, 8'h00);
    check("t2_armed_active", 32'(a_fa), 32'h1);
    a_line(8'h41, 8);
    a_line(8'h49, 8);
    a_vblank(3);
    check("t2_nwr",   32'(a_q_addr.size()), 32'd8);
    check("t2_addr0", a_addr_at(0), 32'd0);
    check("t2_dout0", a_dout_at(0), 32'h4142);
    check("t2_addr7", a_addr_at(7), 32'd7);
    check("t2_dout7", a_dout_at(7), 32'h4F50);
    check("t2_ce",    32'(a_ce_n), 32'd1);
    check("t2_fcnt",  32'(a_fcnt), 32'd2);

    // Overlong line and extra line
    a_clear();
    a_step(1'b0, 1'b0, 8'h00);
    a_line(8'h61, 12);
    check("t4_hlen",    32'(a_eh), 32'h1);
    check("t4_vlen0",   32'(a_ev), 32'h0);
    check("t4_nwr_l0",  32'(a_q_addr.size()), 32'd4);
    check("t4_addr3",   a_addr_at(3), 32'd3);
    check("t4_dout3",   a_dout_at(3), 32'h6768);
    a_line(8'h71, 8);
    a_line(8'h81, 8);
    check("t4_vlen",    32'(a_ev), 32'h1);
    check("t4_nwr",     32'(a_q_addr.size()), 32'd8);
    check("t4_addr7",   a_addr_at(7), 32'd7);
    check("t4_dout7",   a_dout_at(7), 32'h7778);
    a_vblank(3);
    check("t4_sticky",  {30'h0, a_eh, a_ev}, 32'h3);
    check("t4_fcnt",    32'(a_fcnt), 32'd3);
    a_step(1'b0, 1'b0, 8'h00);
    check("t4_cleared", {30'h0, a_eh, a_ev}, 32'h0);

    // Odd byte count: trailing byte dropped, next line realigned
    a_clear();
    a_line(8'h91, 5);
    a_line(8'hA1, 4);
    a_vblank(3);
    check("t5_nwr",   32'(a_q_addr.size()), 32'd4);
    check("t5_dout0", a_dout_at(0), 32'h9192);
    check("t5_dout1", a_dout_at(1), 32'h9394);
    check("t5_dout2", a_dout_at(2), 32'hA1A2);
    check("t5_addr2", a_addr_at(2), 32'd2);
    check("t5_dout3", a_dout_at(3), 32'hA3A4);
    check("t5_hlen",  32'(a_eh), 32'h0);
    check("t5_fcnt",  32'(a_fcnt), 32'd4);

    // Reset mid-line, released with vsync low
    a_step(1'b0, 1'b0, 8'h00);
    a_step(1'b0, 1'b1, 8'hC1);
    a_step(1'b0, 1'b1, 8'hC2);
    a_step(1'b0, 1'b1, 8'hC3);
    rst = 1'b1;
    #1;
    check("t6_rst_fcnt",   32'(a_fcnt), 32'd0);
    check("t6_rst_active", 32'(a_fa),   32'h0);
    check("t6_rst_we",     32'(a_fb.we), 32'h0);
    a_step(1'b0, 1'b1, 8'hC4);
    rst = 1'b0;
    a_clear();
    a_line(8'hD1, 8);
    a_step(1'b0, 1'b0, 8'h00);
    a_line(8'hD9, 8);
    check("t6_sync_nwr", 32'(a_q_addr.size()), 32'd0);
    a_vblank(2);
    a_step(1'b0, 1'b0, 8'h00);
    a_line(8'hE1, 8);
    a_vblank(3);
    check("t6_nwr",   32'(a_q_addr.size()), 32'd4);
    check("t6_addr0", a_addr_at(0), 32'd0);
    check("t6_dout0", a_dout_at(0), 32'hE1E2);
    check("t6_ce",    32'(a_ce_n), 32'd1);
    check("t6_fcnt",  32'(a_fcnt), 32'd1);

    // Decimated 1-byte frame on instance B, pixel value = row*4+col
    b_arm = 1'b1;
    b_step(1'b1, 1'b0, 8'h00);
    b_step(1'b1, 1'b0, 8'h00);
    b_step(1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) b_step(1'b0, 1'b1, 8'(r * 4 + c));
      b_step(1'b0, 1'b0, 8'h00);
      b_step(1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 3; i++) b_step(1'b1, 1'b0, 8'h00);
    check("t3_nwr",   32'(b_q_addr.size()), 32'd4);
    check("t3_dout0", b_dout_at(0), 32'h00);
    check("t3_dout1", b_dout_at(1), 32'h02);
    check("t3_dout2", b_dout_at(2), 32'h08);
    check("t3_dout3", b_dout_at(3), 32'h0A);
    check("t3_addr1", b_addr_at(1), 32'd1);
    check("t3_addr3", b_addr_at(3), 32'd3);
    check("t3_ce",    32'(b_ce_n), 32'd1);
    check("t3_fcnt",  32'(b_fcnt), 32'd1);
    check("t3_errs",  {30'h0, b_eh, b_ev}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
